prog_loader: RTL and testbench
==============================

# prog_loader

Program loader and instruction-store responder for the RV32 single-cycle core. It accepts a little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit words and writes them into an `(INS+1)`-word instruction store. It answers the core's combinational fetch by PC and raises `core_run` once the program is complete. It is the writer and server side of the instruction array that the core top reads.

## Interface
- `INS`, default 5: highest word index. The store holds `INS+1` words, indexed `0..INS`.
- `SENTINEL`, default `32'haaaaaaaa`: the end-of-program / exit word.

Ports:
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `restart` input, 1: synchronous re-initialise and return to LOAD.
- `in_byte` input, 8: program byte.
- `in_valid` input, 1: `in_byte` is valid.
- `in_ready` output, 1: loader accepts a byte this cycle.
- `pc` input, 32: fetch byte address from the core.
- `instr` output, 32: fetched instruction (combinational).
- `core_run` output, 1: program loaded; core may execute.
- `word_count` output, `$clog2(INS+2)`: number of words written since the last reset or restart.

## Operation
- States: LOAD and RUN.
- Reset (`rst`) or `restart`, both synchronous:
  - state becomes LOAD;
  - byte index, word_count and partial-word register clear to 0;
  - every store word becomes `SENTINEL`;
  - `core_run` is 0.
  - `rst` has priority; `restart` behaves identically.
- `in_ready = (state==LOAD) && !restart && !rst`.
- Byte accept, when `in_valid && in_ready` at an edge:
  - byte index k (0..3) loads partial bits `[8k+7:8k]`, little-endian;
  - k increments, wrapping 3 to 0.
- Word write, on the 4th byte (k==3):
  - the assembled word `{in_byte, partial[23:0]}` is written to `store[word_count]`;
  - `word_count` increments.
  - In the same edge, state goes to RUN if the assembled word equals `SENTINEL`, or if the new `word_count == INS+1` (store full).
  - The sentinel word itself is stored.
- In RUN:
  - `in_ready` is 0 and no bytes are accepted;
  - the store is read-only;
  - RUN is left only by `rst` or `restart`.
- Fetch, purely combinational:
  - word address `wa = pc[31:2]`; `pc[1:0]` is ignored;
  - `instr = store[wa]` if `wa <= INS`, else `SENTINEL`.
  - An unloaded or out-of-range fetch therefore returns the exit word.
- Fetch is valid in both states. The core must be held by `core_run` = 0; the loader does not gate fetch.
- A partial word (1–3 bytes) pending at restart is discarded.

## Timing
- Byte latency: the accepted byte is registered at the accept edge. The word write happens at the 4th accept edge.
- `instr` reflects a new word from the cycle after its write edge; there is no extra read latency.
- `core_run` rises in the cycle after the edge that wrote the terminating word (sentinel or full).
- `word_count` updates at the write edge.
- `restart` asserted with `in_valid`: restart wins; the byte is not accepted and `in_ready` reads 0 that cycle.
- Back-to-back accepts every cycle are supported. `in_valid` low stalls with no state change.
- Reset values: `in_ready` 1 (once `rst` is low), `core_run` 0, `word_count` 0, `instr` = `SENTINEL` for any `pc`.

## Test plan
- **Reset value**: reset, then `pc=0`, 4, 24 -> `instr=32'haaaaaaaa` each; `core_run=0`; `word_count=0`.
- **Normal load with sentinel**:
  - stream bytes `93 00 10 00`, `13 01 20 00`, `aa aa aa aa` -> `store[0]=32'h00100093`, `store[1]=32'h00200113`, `store[2]=32'haaaaaaaa`;
  - `word_count=3`; `core_run=1` one cycle after the 12th byte; `in_ready=0` thereafter.
- **Full store**: `INS=5`, six non-sentinel words -> `core_run=1` after the 24th byte; a 25th byte offered is never accepted (`in_ready=0`).
- **Fetch mapping**:
  - after load, `pc=32'h5` returns `store[1]`;
  - `pc=32'h18` (`wa=6 > INS`) returns `32'haaaaaaaa`.
- **Stall and gaps**: `in_valid` toggling with random gaps between bytes -> the same words as the gap-free load; `word_count` increments only on 4th bytes.
- **Restart mid-word and in RUN**:
  - 2 bytes, then `restart` -> `word_count=0`, store reads all sentinel, and the next 4 bytes form `store[0]`;
  - `restart` in RUN -> `core_run=0` next cycle and `in_ready=1`.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader
//   Program loader and instruction-store responder for the RV32 single-cycle
//   core. A little-endian byte stream arrives over a valid/ready handshake.
//   The bytes are packed into 32-bit words and written into an (INS+1)-word
//   store. The store answers the core's combinational fetch by PC.
//   core_run rises once a sentinel word has been stored or the store is full.
//
// Parameters
//   INS        highest word index; the store holds INS+1 words (0..INS)
//   SENTINEL   end-of-program / exit word, and the value of every empty slot
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (priority over restart)
//   restart     in   synchronous re-initialise, return to LOAD
//   in_byte     in   [7:0]  program byte
//   in_valid    in   in_byte is valid
//   in_ready    out  loader accepts a byte this cycle
//   pc          in   [31:0] fetch byte address
//   instr       out  [31:0] fetched word (combinational)
//   core_run    out  program loaded; core may execute
//   word_count  out  words written since the last reset/restart
module prog_loader #(
    parameter int          INS      = 5,
    parameter logic [31:0] SENTINEL = 32'haaaaaaaa
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        restart,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 pc,
    output logic [31:0]                 instr,
    output logic                        core_run,
    output logic [$clog2(INS+2)-1:0]    word_count
);

    localparam int WCW = $clog2(INS + 2);
    localparam int AW  = (INS > 0) ? $clog2(INS + 1) : 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_partial;
    logic [WCW-1:0]    r_word_count;
    logic              r_core_run;
    logic [31:0]       r_store [0:INS];

    logic              w_accept;
    logic              w_write;
    logic [31:0]       w_word;
    logic [WCW-1:0]    w_word_count_next;
    logic [29:0]       w_wa;
    logic [1:0]        w_unused_pc_lo;

    // restart and rst block the handshake in the same cycle so a byte
    // presented alongside them is never consumed.
    assign in_ready          = (r_state == S_LOAD) && !restart && !rst;
    assign w_accept          = in_valid && in_ready;
    assign w_write           = w_accept && (r_byte_idx == 2'd3);
    assign w_word            = {in_byte, r_partial};
    assign w_word_count_next = r_word_count + 1'b1;

    // Control state: byte packing, word counter and LOAD/RUN sequencing.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state      <= S_LOAD;
            r_byte_idx   <= 2'd0;
            r_partial    <= 24'd0;
            r_word_count <= '0;
            r_core_run   <= 1'b0;
        end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
                2'd0: r_partial[7:0]   <= in_byte;
                2'd1: r_partial[15:8]  <= in_byte;
                2'd2: r_partial[23:16] <= in_byte;
                default: begin
                    // Fourth byte: the word is written by the store below.
                    r_word_count <= w_word_count_next;
                    if ((w_word == SENTINEL) ||
                        (w_word_count_next == WCW'(INS + 1))) begin
                        r_state    <= S_RUN;
                        r_core_run <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Store: one register per word so that reset can refill every slot
    // with the sentinel in a single cycle.
    generate
        for (genvar gi = 0; gi <= INS; gi++) begin : g_store
            always_ff @(posedge clk) begin
                if (rst || restart) begin
                    r_store[gi] <= SENTINEL;
                end else if (w_write && (r_word_count == WCW'(gi))) begin
                    r_store[gi] <= w_word;
                end
            end
        end
    endgenerate

    // Fetch: word-addressed, byte offset ignored; out-of-range returns
    // the exit word so a runaway core stops.
    assign w_wa           = pc[31:2];
    assign w_unused_pc_lo = pc[1:0];

    always_comb begin
        instr = SENTINEL;
        if (w_wa <= 30'(INS)) begin
            instr = r_store[w_wa[AW-1:0]];
        end
    end

    assign core_run   = r_core_run;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int          INS      = 5;
    localparam logic [31:0] SENTINEL = 32'haaaaaaaa;

    logic        clk;
    logic        rst;
    logic        restart;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_run;
    logic [2:0]  word_count;

    int errors = 0;
    int checks = 0;

    prog_loader #(.INS(INS), .SENTINEL(SENTINEL)) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc         (pc),
        .instr      (instr),
        .core_run   (core_run),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for one edge; caller guarantees LOAD state.
    task automatic send_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #0;
        end
    endtask

    task automatic read_at(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        pc = addr;
        #1;
        chk(tag, instr, exp);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    logic [31:0] prog [0:2];
    logic [31:0] full_w;

    initial begin
        prog[0] = 32'h00100093;
        prog[1] = 32'h00200113;
        prog[2] = SENTINEL;

        rst = 1'b1; restart = 1'b0; in_byte = 8'h00; in_valid = 1'b0; pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        read_at(32'h0,  "reset_instr_pc0",  SENTINEL);
        read_at(32'h4,  "reset_instr_pc4",  SENTINEL);
        read_at(32'h18, "reset_instr_pc24", SENTINEL);
        chk("reset_core_run",   32'(core_run),   32'd0);
        chk("reset_word_count", 32'(word_count), 32'd0);
        chk("reset_in_ready",   32'(in_ready),   32'd1);

        // Normal load ending in sentinel
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        send_byte(8'haa); send_byte(8'haa); send_byte(8'haa);
        chk("load_pre_core_run",   32'(core_run),   32'd0);
        chk("load_pre_word_count", 32'(word_count), 32'd2);
        send_byte(8'haa);
        chk("load_core_run",   32'(core_run),   32'd1);
        chk("load_word_count", 32'(word_count), 32'd3);
        chk("load_in_ready",   32'(in_ready),   32'd0);
        read_at(32'h0,  "load_store0", 32'h00100093);
        read_at(32'h4,  "load_store1", 32'h00200113);
        read_at(32'h8,  "load_store2", SENTINEL);
        read_at(32'hc,  "load_store3_empty", SENTINEL);
        read_at(32'h5,  "fetch_pc5", 32'h00200113);
        read_at(32'h18, "fetch_pc18_oob", SENTINEL);

        // Byte offered in RUN is ignored
        send_byte(8'h55);
        chk("run_ignore_word_count", 32'(word_count), 32'd3);
        read_at(32'hc, "run_ignore_store3", SENTINEL);

        // Restart in RUN with a byte offered in the same cycle
        restart = 1'b1; in_valid = 1'b1; in_byte = 8'h77;
        #1;
        chk("restart_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        restart = 1'b0; in_valid = 1'b0;
        #1;
        chk("restart_core_run",   32'(core_run),   32'd0);
        chk("restart_in_ready",   32'(in_ready),   32'd1);
        chk("restart_word_count", 32'(word_count), 32'd0);
        read_at(32'h0, "restart_store0", SENTINEL);
        read_at(32'h4, "restart_store1", SENTINEL);

        // Restart mid-word discards the partial bytes
        send_byte(8'h11); send_byte(8'h22);
        do_restart();
        chk("midword_word_count", 32'(word_count), 32'd0);
        read_at(32'h0, "midword_store0_cleared", SENTINEL);
        send_word(32'h12345678, 0);
        chk("midword_after_word_count", 32'(word_count), 32'd1);
        read_at(32'h0, "midword_store0", 32'h12345678);

        // Load with random gaps between bytes
        do_restart();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(prog[w][8*i +: 8]);
                chk($sformatf("gap_wc_w%0d_b%0d", w, i), 32'(word_count),
                    (i == 3) ? 32'(w + 1) : 32'(w));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        chk("gap_core_run", 32'(core_run), 32'd1);
        read_at(32'h0, "gap_store0", 32'h00100093);
        read_at(32'h4, "gap_store1", 32'h00200113);
        read_at(32'h8, "gap_store2", SENTINEL);

        // Full store: six non-sentinel words
        do_restart();
        for (int w = 0; w < 6; w++) begin
            full_w = 32'h11111111 * (w + 1);
            if (w < 5) begin
                send_word(full_w, 0);
            end else begin
                send_byte(full_w[7:0]); send_byte(full_w[15:8]); send_byte(full_w[23:16]);
                chk("full_pre_core_run", 32'(core_run), 32'd0);
                send_byte(full_w[31:24]);
            end
        end
        chk("full_core_run",   32'(core_run),   32'd1);
        chk("full_word_count", 32'(word_count), 32'd6);
        chk("full_in_ready",   32'(in_ready),   32'd0);
        send_byte(8'h99);
        chk("full_25th_word_count", 32'(word_count), 32'd6);
        read_at(32'h0,  "full_store0", 32'h11111111);
        read_at(32'h14, "full_store5", 32'h66666666);
        read_at(32'h18, "full_oob",    SENTINEL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
